// File: rtl/ssram_arb2.sv
// Round-robin arbiter with bounded lock for two requesters sharing one
// single-port write-first synchronous RAM; read data is steered back by flag.
module ssram_arb2 #(
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_LOCK   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic                  lock0,
  input  logic                  lock1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [WORD_WIDTH-1:0] wdata0,
  input  logic [WORD_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [WORD_WIDTH-1:0] rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [WORD_WIDTH-1:0] ram_din,
  input  logic [WORD_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam logic [7:0] LockMax = 8'(MAX_LOCK);

  owner_e     owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] lcnt_q, lcnt_d;
  logic       rv0_q, rv0_d;
  logic       rv1_q, rv1_d;

  logic       lock_room;
  logic       granted;
  logic       sel_lock;
  logic       was_owner;

  assign lock_room = (lcnt_q < LockMax);

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch can be inferred on an unassigned path.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (owner_q == OWN_0 && req0 && (!req1 || lock_room)) begin
        gnt0 = 1'b1;
      end else if (owner_q == OWN_1 && req1 && (!req0 || lock_room)) begin
        gnt1 = 1'b1;
      end else if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        // Contention goes to whoever was not served last.
        if (last_q) gnt0 = 1'b1;
        else        gnt1 = 1'b1;
      end
    end
  end

  assign granted   = gnt0 | gnt1;
  assign sel_lock  = gnt1 ? lock1 : lock0;
  assign was_owner = (gnt0 && owner_q == OWN_0) || (gnt1 && owner_q == OWN_1);

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    lcnt_d  = lcnt_q;
    if (granted) begin
      last_d = gnt1;
      if (sel_lock) begin
        owner_d = gnt1 ? OWN_1 : OWN_0;
        if (!was_owner)           lcnt_d = 8'd1;
        else if (lcnt_q != 8'hFF) lcnt_d = lcnt_q + 8'd1;
      end else begin
        owner_d = OWN_NONE;
        lcnt_d  = 8'd0;
      end
    end else if ((owner_q == OWN_0 && !req0) || (owner_q == OWN_1 && !req1)) begin
      // Owner walked away without taking a grant: drop the lock.
      owner_d = OWN_NONE;
      lcnt_d  = 8'd0;
    end
    rv0_d = gnt0 & ~we0;
    rv1_d = gnt1 & ~we1;
  end

  // NOTE: state registers use non-blocking '<=' and a synchronous reset; the
  // RAM contents are never reset here, only the control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b1;
      owner_q <= OWN_NONE;
      lcnt_q  <= 8'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      lcnt_q  <= lcnt_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign ram_en   = granted;
  assign ram_we   = (gnt0 & we0) | (gnt1 & we1);
  assign ram_addr = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
  assign ram_din  = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

  // Gating by rst drops a read return that would land in a reset cycle.
  assign rvalid0 = rv0_q & ~rst;
  assign rvalid1 = rv1_q & ~rst;
  assign rdata   = ram_dout;

endmodule
